pwm_meter: RTL and testbench

- Receive-side counterpart of the team's PWM generator: measures an incoming PWM waveform and reports high time and period in clk cycles.
- Used for loopback-testing the generator and for decoding external PWM sensors/servo inputs.
- Input is asynchronous and is synchronized internally.
- Reports a fresh measurement once per PWM period.
- Flags a stuck line (0 % or 100 % duty, or a period too long to measure).

---
 rtl/pwm_pkg.sv | 9 +
 rtl/sync_ff.sv | 17 +
 rtl/pwm_meter.sv | 72 +++++++
 tb/tb_pwm_meter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared arithmetic for the PWM blocks (generator, meter).
package pwm_pkg;

  // Saturating increment used by every PWM counter: sticks at max, never wraps.
  function automatic logic [31:0] sat_inc(input logic [31:0] x, input logic [31:0] max);
    return (x >= max) ? max : x + 32'd1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Plain multi-stage synchronizer for asynchronous single-bit inputs; no reset.
module sync_ff #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [stages-1:0] chain;

  always_ff @(posedge clk)
    chain <= {chain[stages-2:0], d};

  assign q = chain[stages-1];

endmodule

// File: rtl/pwm_meter.sv
// Measures high time and period of an asynchronous PWM input in clk cycles,
// one measurement per period, and flags a line with no rising edge.
module pwm_meter
  import pwm_pkg::*;
#(
  parameter int cntBits    = 8,
  parameter int syncStages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic [cntBits:0] high,
  output logic [cntBits:0] period,
  output logic             valid,
  output logic             stuck,
  output logic             level
);

  localparam int         W   = cntBits + 1;
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic         s, s_d, rise, armed;
  logic [W-1:0] per_cnt, hi_cnt;

  sync_ff #(.stages(syncStages)) u_sync (
    .clk (clk),
    .d   (in),
    .q   (s)
  );

  assign rise = s & ~s_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_d     <= 1'b0;
      per_cnt <= '0;
      hi_cnt  <= '0;
      armed   <= 1'b0;
      high    <= '0;
      period  <= '0;
      valid   <= 1'b0;
      stuck   <= 1'b0;
      level   <= 1'b0;
    end else begin
      s_d   <= s;
      valid <= 1'b0;
      if (rise) begin
        per_cnt <= ONE;
        hi_cnt  <= ONE;
        // The arming rise after reset or a stuck episode only starts a period.
        if (armed && !stuck) begin
          period <= per_cnt;
          high   <= hi_cnt;
          valid  <= 1'b1;
        end
        armed <= 1'b1;
        stuck <= 1'b0;
      end else begin
        per_cnt <= W'(sat_inc(32'(per_cnt), 32'(MAX)));
        if (s)
          hi_cnt <= W'(sat_inc(32'(hi_cnt), 32'(MAX)));
        if (per_cnt == MAX) begin
          stuck <= 1'b1;
          level <= s;
          armed <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_meter.sv
// Directed bench for pwm_meter: pattern generator, valid monitor, scenario tasks.
module tb_pwm_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pin = 1'b0;
  logic [8:0] high, period;
  logic       valid, stuck, level;

  int n_cmp = 0, n_bad = 0;

  // generator: mode 0 = const low, 1 = const high, 2 = gen_hi high / gen_lo low
  int mode = 0, gen_hi = 5, gen_lo = 7, ph = 0;

  int vcnt = 0, cyc = 0, last_stamp = 0, last_gap = 0, b2b = 0, badinv = 0;
  logic [8:0] last_high = '0, last_period = '0;
  bit prev_v = 1'b0;

  pwm_meter #(.cntBits(8), .syncStages(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (pin),
    .high   (high),
    .period (period),
    .valid  (valid),
    .stuck  (stuck),
    .level  (level)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) pin = 1'b0;
      else if (mode == 1) pin = 1'b1;
      else begin
        pin = (ph < gen_hi);
        ph = (ph + 1 >= gen_hi + gen_lo) ? 0 : ph + 1;
      end
    end
  end

  always @(posedge clk) begin
    #3;
    cyc++;
    if (valid) begin
      vcnt++;
      last_high   = high;
      last_period = period;
      last_gap    = cyc - last_stamp;
      last_stamp  = cyc;
      if (prev_v) b2b++;
      if (high < 9'd1 || high > period) badinv++;
    end
    prev_v = valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic wait_valid(input int bound, output int waited, output bit ok);
    int v0;
    v0 = vcnt; ok = 1'b0; waited = 0;
    while (!ok && waited < bound) begin
      @(negedge clk);
      waited++;
      if (vcnt != v0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    mode = 0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (high !== 9'd0)   begin n_bad++; $display("FAIL reset_high: got %0d want 0", high); end
    n_cmp++; if (period !== 9'd0) begin n_bad++; $display("FAIL reset_period: got %0d want 0", period); end
    n_cmp++; if (valid !== 1'b0)  begin n_bad++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_cmp++; if (stuck !== 1'b0)  begin n_bad++; $display("FAIL reset_stuck: got %0b want 0", stuck); end
    n_cmp++; if (level !== 1'b0)  begin n_bad++; $display("FAIL reset_level: got %0b want 0", level); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_low();
    int v0, w;
    bit ok;
    v0 = vcnt;
    repeat (511) @(negedge clk);
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL idle_stuck_early: got %0b want 0", stuck); end
    @(negedge clk);
    n_cmp++; if (stuck !== 1'b1) begin n_bad++; $display("FAIL idle_stuck: got %0b want 1", stuck); end
    n_cmp++; if (level !== 1'b0) begin n_bad++; $display("FAIL idle_level: got %0b want 0", level); end
    n_cmp++; if (vcnt !== v0)    begin n_bad++; $display("FAIL idle_novalid: got %0d valids want 0", vcnt - v0); end
    gen_hi = 5; gen_lo = 7; ph = 0; mode = 2;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (!stuck) ok = 1'b1;
    end
    n_cmp++; if (!ok)         begin n_bad++; $display("FAIL idle_unstick: got stuck=1 want 0 within 10 cycles"); end
    n_cmp++; if (vcnt !== v0) begin n_bad++; $display("FAIL idle_arm_only: got %0d valids want 0", vcnt - v0); end
    wait_valid(20, w, ok);
    n_cmp++; if (!ok)                begin n_bad++; $display("FAIL idle_first_valid: got timeout want valid"); end
    n_cmp++; if (last_high !== 9'd5)    begin n_bad++; $display("FAIL idle_high: got %0d want 5", last_high); end
    n_cmp++; if (last_period !== 9'd12) begin n_bad++; $display("FAIL idle_period: got %0d want 12", last_period); end
    wait_valid(20, w, ok);
    n_cmp++; if (last_gap !== 12) begin n_bad++; $display("FAIL idle_gap: got %0d want 12", last_gap); end
  endtask

  task automatic test_stuck_high();
    int v0, w;
    bit ok;
    mode = 1;
    repeat (30) @(negedge clk);
    v0 = vcnt;
    repeat (570) @(negedge clk);
    n_cmp++; if (stuck !== 1'b1) begin n_bad++; $display("FAIL high_stuck: got %0b want 1", stuck); end
    n_cmp++; if (level !== 1'b1) begin n_bad++; $display("FAIL high_level: got %0b want 1", level); end
    n_cmp++; if (vcnt !== v0)    begin n_bad++; $display("FAIL high_novalid: got %0d valids want 0", vcnt - v0); end
    ph = 0; mode = 2;
    wait_valid(40, w, ok);
    n_cmp++; if (!ok)                   begin n_bad++; $display("FAIL high_rearm: got timeout want valid"); end
    n_cmp++; if (last_high !== 9'd5)    begin n_bad++; $display("FAIL high_high: got %0d want 5", last_high); end
    n_cmp++; if (last_period !== 9'd12) begin n_bad++; $display("FAIL high_period: got %0d want 12", last_period); end
    n_cmp++; if (stuck !== 1'b0)        begin n_bad++; $display("FAIL high_unstuck: got %0b want 0", stuck); end
  endtask

  task automatic test_min_pulse();
    int early, w;
    bit ok;
    test_reset();
    gen_hi = 2; gen_lo = 2; ph = 0; mode = 2;
    early = 0;
    repeat (7) begin
      @(negedge clk);
      if (valid) early++;
    end
    n_cmp++; if (early !== 0)  begin n_bad++; $display("FAIL min_early: got %0d valids want 0", early); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b1)   begin n_bad++; $display("FAIL min_latency: got valid=%0b want 1", valid); end
    n_cmp++; if (high !== 9'd2)    begin n_bad++; $display("FAIL min_high: got %0d want 2", high); end
    n_cmp++; if (period !== 9'd4)  begin n_bad++; $display("FAIL min_period: got %0d want 4", period); end
    wait_valid(8, w, ok);
    n_cmp++; if (!ok || last_gap !== 4) begin n_bad++; $display("FAIL min_gap: got %0d want 4", last_gap); end
    n_cmp++; if (last_high !== 9'd2 || last_period !== 9'd4)
      begin n_bad++; $display("FAIL min_repeat: got %0d/%0d want 2/4", last_high, last_period); end
  endtask

  task automatic test_reset_mid();
    int w;
    bit ok;
    gen_hi = 10; gen_lo = 10; ph = 0; mode = 2;
    wait_valid(60, w, ok);
    wait_valid(60, w, ok);
    n_cmp++; if (last_high !== 9'd10 || last_period !== 9'd20)
      begin n_bad++; $display("FAIL mid_pre: got %0d/%0d want 10/20", last_high, last_period); end
    ok = 1'b0;
    for (int i = 0; i < 25 && !ok; i++) begin
      @(negedge clk);
      if (ph == 15) ok = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (high !== 9'd0 || period !== 9'd0 || valid !== 1'b0 || stuck !== 1'b0)
      begin n_bad++; $display("FAIL mid_clear: got h=%0d p=%0d v=%0b s=%0b want 0", high, period, valid, stuck); end
    rst_n = 1'b1;
    wait_valid(60, w, ok);
    n_cmp++; if (!ok || w <= 20) begin n_bad++; $display("FAIL mid_first: got wait %0d ok=%0b want >20 and valid", w, ok); end
    n_cmp++; if (last_high !== 9'd10)   begin n_bad++; $display("FAIL mid_high: got %0d want 10", last_high); end
    n_cmp++; if (last_period !== 9'd20) begin n_bad++; $display("FAIL mid_period: got %0d want 20", last_period); end
  endtask

  task automatic test_duty_change();
    int w;
    bit ok;
    gen_hi = 123; gen_lo = 133; ph = 0; mode = 2;
    repeat (3) wait_valid(600, w, ok);
    n_cmp++; if (!ok)                    begin n_bad++; $display("FAIL loop_valid: got timeout want valid"); end
    n_cmp++; if (last_high !== 9'd123)   begin n_bad++; $display("FAIL loop_high: got %0d want 123", last_high); end
    n_cmp++; if (last_period !== 9'd256) begin n_bad++; $display("FAIL loop_period: got %0d want 256", last_period); end
    n_cmp++; if (last_gap !== 256)       begin n_bad++; $display("FAIL loop_gap: got %0d want 256", last_gap); end
    gen_hi = 1; gen_lo = 255;
    repeat (3) wait_valid(600, w, ok);
    n_cmp++; if (!ok)                    begin n_bad++; $display("FAIL duty_valid: got timeout want valid"); end
    n_cmp++; if (last_high !== 9'd1)     begin n_bad++; $display("FAIL duty_high: got %0d want 1", last_high); end
    n_cmp++; if (last_period !== 9'd256) begin n_bad++; $display("FAIL duty_period: got %0d want 256", last_period); end
    n_cmp++; if (last_gap !== 256)       begin n_bad++; $display("FAIL duty_gap: got %0d want 256", last_gap); end
  endtask

  task automatic test_invariants();
    n_cmp++; if (b2b !== 0)    begin n_bad++; $display("FAIL valid_b2b: got %0d want 0", b2b); end
    n_cmp++; if (badinv !== 0) begin n_bad++; $display("FAIL high_le_period: got %0d violations want 0", badinv); end
  endtask

  initial begin
    test_reset();
    test_idle_low();
    test_stuck_high();
    test_min_pulse();
    test_reset_mid();
    test_duty_change();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
